addsub_arbiter: RTL and testbench

Shares the single ALU adder/subtractor between the multicycle extension units (cube root, square root, final result sum) and any later requesters. Each requester presents one 8-bit add or subtract operation with a level request. The arbiter picks a winner, drives the shared adder with that operation, registers the result and returns it with a one-cycle ready pulse. It replaces the combinational encoder/decoder/mux selection in the ALU with a fair, registered scheduler.

---
 rtl/addsub_arbiter_if.sv | 28 ++
 rtl/addsub_arbiter.sv | 116 +++++++++++
 tb/tb_addsub_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_arbiter_if.sv
// Requester and shared adder/subtractor bundle for addsub_arbiter.
// The slave modport is the arbiter; the master modport is the requester/adder side.
interface addsub_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    logic [NREQ-1:0]   req_i;
    logic [NREQ-1:0]   mode_i;
    logic [NREQ*W-1:0] a_i;
    logic [NREQ*W-1:0] b_i;
    logic [NREQ-1:0]   ready_o;
    logic [W-1:0]      res_o;
    logic              as_add_o;
    logic [W-1:0]      as_a_o;
    logic [W-1:0]      as_b_o;
    logic [W-1:0]      as_res_i;
    logic              busy_o;

    modport slave (
        input  req_i, mode_i, a_i, b_i, as_res_i,
        output ready_o, res_o, as_add_o, as_a_o, as_b_o, busy_o
    );

    modport master (
        output req_i, mode_i, a_i, b_i, as_res_i,
        input  ready_o, res_o, as_add_o, as_a_o, as_b_o, busy_o
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Registered scheduler granting the shared adder/subtractor to one of NREQ requesters,
// one operation per three cycles, with round-robin or fixed-priority selection.
module addsub_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int RR   = 1
) (
    input  logic              clk_i,
    input  logic              rst_n,
    addsub_arbiter_if.slave   bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   g_reg;
    logic [PW-1:0]   ptr_next;
    logic            op_add_reg;
    logic [W-1:0]    op_a_reg;
    logic [W-1:0]    op_b_reg;
    logic [W-1:0]    res_reg;
    logic [NREQ-1:0] ready_reg;

    logic [PW-1:0]   grant_idx;
    logic            grant_vld;
    logic [W-1:0]    a_arr    [NREQ];
    logic [W-1:0]    b_arr    [NREQ];
    logic [PW-1:0]   cand_idx [NREQ];

    // cand_idx[i] is the requester examined i-th; earlier candidates win.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign a_arr[gi] = bus.a_i[gi*W +: W];
            assign b_arr[gi] = bus.b_i[gi*W +: W];
            if (RR != 0) begin : g_rr
                logic [PW:0] rot;
                assign rot = {1'b0, ptr_reg} + (PW+1)'(gi);
                assign cand_idx[gi] = (rot >= (PW+1)'(NREQ)) ? PW'(rot - (PW+1)'(NREQ))
                                                             : rot[PW-1:0];
            end else begin : g_fp
                assign cand_idx[gi] = PW'(gi);
            end
        end
    endgenerate

    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_i[cand_idx[i]]) begin
                grant_idx = cand_idx[i];
                grant_vld = 1'b1;
            end
        end
    end

    assign ptr_next = (g_reg == PW'(NREQ - 1)) ? '0 : g_reg + PW'(1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_vld) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            g_reg      <= '0;
            op_add_reg <= 1'b0;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            res_reg    <= '0;
            ready_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ready_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (grant_vld) begin
                        g_reg      <= grant_idx;
                        op_add_reg <= bus.mode_i[grant_idx];
                        op_a_reg   <= a_arr[grant_idx];
                        op_b_reg   <= b_arr[grant_idx];
                    end
                end
                ISSUE: begin
                    // Result and pulse are registered together so both are valid in RESP.
                    res_reg   <= bus.as_res_i;
                    ready_reg <= NREQ'(1) << g_reg;
                end
                RESP: begin
                    ptr_reg <= ptr_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_o  = ready_reg;
    assign bus.res_o    = res_reg;
    assign bus.as_add_o = op_add_reg;
    assign bus.as_a_o   = op_a_reg;
    assign bus.as_b_o   = op_b_reg;
    assign bus.busy_o   = (state_reg != IDLE);
endmodule

// File: tb/tb_addsub_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus and
// compares both against a transaction-level model of grants and modular arithmetic.
module tb_addsub_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 8;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [NREQ-1:0]   req_drv  = '0;
    logic [NREQ-1:0]   mode_drv = '0;
    logic [NREQ*W-1:0] a_drv    = '0;
    logic [NREQ*W-1:0] b_drv    = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_rr   = 0;
    int op_count = 0;

    logic [W-1:0]    op_a [NREQ];
    logic [W-1:0]    op_b [NREQ];
    logic [NREQ-1:0] op_req;
    logic [NREQ-1:0] op_mode;
    logic [W-1:0]    last_res_rr;
    logic [NREQ-1:0] last_ready_rr;
    logic [NREQ-1:0] last_ready_fp;

    addsub_arbiter_if #(.NREQ(NREQ), .W(W)) rr_if ();
    addsub_arbiter_if #(.NREQ(NREQ), .W(W)) fp_if ();

    assign rr_if.req_i  = req_drv;
    assign rr_if.mode_i = mode_drv;
    assign rr_if.a_i    = a_drv;
    assign rr_if.b_i    = b_drv;
    assign fp_if.req_i  = req_drv;
    assign fp_if.mode_i = mode_drv;
    assign fp_if.a_i    = a_drv;
    assign fp_if.b_i    = b_drv;

    // Shared adder/subtractor seen by each arbiter.
    assign rr_if.as_res_i = rr_if.as_add_o ? W'(rr_if.as_a_o + rr_if.as_b_o)
                                           : W'(rr_if.as_a_o - rr_if.as_b_o);
    assign fp_if.as_res_i = fp_if.as_add_o ? W'(fp_if.as_a_o + fp_if.as_b_o)
                                           : W'(fp_if.as_a_o - fp_if.as_b_o);

    addsub_arbiter #(.NREQ(NREQ), .W(W), .RR(1)) u_rr (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (rr_if.slave)
    );

    addsub_arbiter #(.NREQ(NREQ), .W(W), .RR(0)) u_fp (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (fp_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (p + i) % NREQ;
            if (r[k]) return k;
        end
        return 0;
    endfunction

    function automatic int fp_pick(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) if (r[k]) return k;
        return 0;
    endfunction

    function automatic logic [W-1:0] ref_calc(input logic add, input int a, input int b);
        int r;
        r = add ? (a + b) : (a - b);
        r = ((r % 256) + 256) % 256;
        return W'(r);
    endfunction

    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            a_drv[k*W +: W] = op_a[k];
            b_drv[k*W +: W] = op_b[k];
        end
        req_drv  = op_req;
        mode_drv = op_mode;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rr_ready"}, 32'(rr_if.ready_o),  32'd0);
        check({tag, "_rr_res"},   32'(rr_if.res_o),    32'd0);
        check({tag, "_rr_busy"},  32'(rr_if.busy_o),   32'd0);
        check({tag, "_rr_asadd"}, 32'(rr_if.as_add_o), 32'd0);
        check({tag, "_rr_asa"},   32'(rr_if.as_a_o),   32'd0);
        check({tag, "_rr_asb"},   32'(rr_if.as_b_o),   32'd0);
        check({tag, "_fp_ready"}, 32'(fp_if.ready_o),  32'd0);
        check({tag, "_fp_res"},   32'(fp_if.res_o),    32'd0);
        check({tag, "_fp_busy"},  32'(fp_if.busy_o),   32'd0);
        check({tag, "_fp_asadd"}, 32'(fp_if.as_add_o), 32'd0);
        check({tag, "_fp_asa"},   32'(fp_if.as_a_o),   32'd0);
        check({tag, "_fp_asb"},   32'(fp_if.as_b_o),   32'd0);
    endtask

    // One IDLE->ISSUE->RESP->IDLE transaction, entered while both DUTs are in IDLE.
    task automatic do_op(input bit perturb, input bit drop);
        int wr, wf;
        logic [W-1:0] er, ef;
        drive();
        op_count++;
        if (op_req == '0) begin
            @(posedge clk_i); #1;
            check("idle_rr_busy",  32'(rr_if.busy_o),  32'd0);
            check("idle_fp_busy",  32'(fp_if.busy_o),  32'd0);
            check("idle_rr_ready", 32'(rr_if.ready_o), 32'd0);
            $display("op %0d req=%b no grant", op_count, op_req);
            return;
        end
        wr = rr_pick(op_req, ptr_rr);
        wf = fp_pick(op_req);
        er = ref_calc(op_mode[wr], int'(op_a[wr]), int'(op_b[wr]));
        ef = ref_calc(op_mode[wf], int'(op_a[wf]), int'(op_b[wf]));

        @(posedge clk_i); #1;
        check("issue_rr_busy",  32'(rr_if.busy_o),   32'd1);
        check("issue_rr_ready", 32'(rr_if.ready_o),  32'd0);
        check("issue_rr_asa",   32'(rr_if.as_a_o),   32'(op_a[wr]));
        check("issue_rr_asb",   32'(rr_if.as_b_o),   32'(op_b[wr]));
        check("issue_rr_asadd", 32'(rr_if.as_add_o), 32'(op_mode[wr]));
        check("issue_fp_busy",  32'(fp_if.busy_o),   32'd1);
        check("issue_fp_ready", 32'(fp_if.ready_o),  32'd0);
        check("issue_fp_asa",   32'(fp_if.as_a_o),   32'(op_a[wf]));
        check("issue_fp_asb",   32'(fp_if.as_b_o),   32'(op_b[wf]));
        check("issue_fp_asadd", 32'(fp_if.as_add_o), 32'(op_mode[wf]));
        if (perturb) begin
            a_drv    = {$urandom};
            b_drv    = {$urandom};
            mode_drv = NREQ'($urandom);
        end
        if (drop) req_drv = '0;

        @(posedge clk_i); #1;
        check("resp_rr_ready", 32'(rr_if.ready_o), 32'(NREQ'(1) << wr));
        check("resp_rr_res",   32'(rr_if.res_o),   32'(er));
        check("resp_rr_busy",  32'(rr_if.busy_o),  32'd1);
        check("resp_fp_ready", 32'(fp_if.ready_o), 32'(NREQ'(1) << wf));
        check("resp_fp_res",   32'(fp_if.res_o),   32'(ef));
        check("resp_fp_busy",  32'(fp_if.busy_o),  32'd1);
        last_res_rr   = rr_if.res_o;
        last_ready_rr = rr_if.ready_o;
        last_ready_fp = fp_if.ready_o;
        ptr_rr = (wr + 1) % NREQ;

        @(posedge clk_i); #1;
        check("post_rr_ready", 32'(rr_if.ready_o), 32'd0);
        check("post_rr_busy",  32'(rr_if.busy_o),  32'd0);
        check("post_fp_ready", 32'(fp_if.ready_o), 32'd0);
        check("post_fp_busy",  32'(fp_if.busy_o),  32'd0);
        $display("op %0d req=%b rr_gnt=%0d rr_res=%0d fp_gnt=%0d fp_res=%0d",
                 op_count, op_req, wr, er, wf, ef);
    endtask

    task automatic set_op(input int k, input logic add, input int a, input int b);
        op_mode[k] = add;
        op_a[k]    = W'(a);
        op_b[k]    = W'(b);
    endtask

    initial begin
        for (int k = 0; k < NREQ; k++) begin
            op_a[k] = '0;
            op_b[k] = '0;
        end
        op_req  = '0;
        op_mode = '0;

        #1;
        check_zero("reset");
        repeat (2) @(posedge clk_i);
        #1 rst_n = 1'b1;

        // Single requester add
        op_req = 4'b0010;
        set_op(1, 1'b1, 20, 7);
        do_op(1'b0, 1'b0);
        check("plan_add_27", 32'(last_res_rr), 32'd27);

        // Subtract and add wrap
        op_req = 4'b0100;
        set_op(2, 1'b0, 3, 5);
        do_op(1'b0, 1'b0);
        check("plan_sub_wrap", 32'(last_res_rr), 32'd254);
        op_req = 4'b1000;
        set_op(3, 1'b1, 200, 100);
        do_op(1'b0, 1'b0);
        check("plan_add_wrap", 32'(last_res_rr), 32'd44);

        // All four requesting: round-robin rotates from ptr=0
        op_req = 4'b1111;
        for (int k = 0; k < NREQ; k++) set_op(k, k[0], 10 * k + 11, k + 3);
        for (int i = 0; i < 5; i++) begin
            do_op(1'b0, 1'b0);
            check("plan_rr_seq", 32'(last_ready_rr), 32'(NREQ'(1) << (i % NREQ)));
        end

        // Fixed priority starves requester 3 while requester 1 holds its request
        op_req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, 1'b0);
            check("plan_fp_hold", 32'(last_ready_fp), 32'b0010);
        end
        op_req = 4'b1000;
        do_op(1'b0, 1'b0);
        check("plan_fp_drop", 32'(last_ready_fp), 32'b1000);

        // Operand change and request drop after grant
        op_req = 4'b0001;
        set_op(0, 1'b1, 55, 66);
        do_op(1'b1, 1'b1);
        check("plan_latched", 32'(last_res_rr), 32'd121);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            op_req = NREQ'($urandom_range(0, 15));
            for (int k = 0; k < NREQ; k++)
                set_op(k, 1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            do_op(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end

        // Reset pulse during ISSUE
        op_req = 4'b1100;
        set_op(2, 1'b1, 9, 9);
        set_op(3, 1'b0, 40, 1);
        drive();
        @(posedge clk_i); #1;
        check("rst_pre_busy", 32'(rr_if.busy_o), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_zero("rst_issue");
        #2 rst_n = 1'b1;
        ptr_rr = 0;
        do_op(1'b0, 1'b0);
        check("rst_regrant", 32'(last_ready_rr), 32'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
